// File: rtl/dot_product_feeder_if.sv
// Bus bundle between the feeder, the chunked vector memory and the dot-product unit.
// The master side is the feeder; the slave side is the memory plus dot-product unit.
interface dot_product_feeder_if #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 16
);
    logic                                 mem_rd_en;
    logic [addr_width-1:0]                mem_addr;
    logic [element_width*no_of_units-1:0] mem_a_data;
    logic [element_width*no_of_units-1:0] mem_b_data;
    logic [element_width*no_of_units-1:0] first_row_plus_additional;
    logic [element_width*no_of_units-1:0] vector2;
    logic                                 outsider_read_now;
    logic                                 I_am_ready;
    logic                                 finish;
    logic [element_width-1:0]             dot_product_output;

    // Chunk handshake: a chunk pair moves on the cycle where outsider_read_now
    // and I_am_ready are both high; until then the presented pair is held stable.
    modport master (
        output mem_rd_en, mem_addr, first_row_plus_additional, vector2, outsider_read_now,
        input  mem_a_data, mem_b_data, I_am_ready, finish, dot_product_output
    );

    modport slave (
        input  mem_rd_en, mem_addr, first_row_plus_additional, vector2, outsider_read_now,
        output mem_a_data, mem_b_data, I_am_ready, finish, dot_product_output
    );
endinterface

// File: rtl/dot_product_feeder.sv
// Streams vectors A and B chunk by chunk from memory into a dot-product unit,
// zero-pads the tail chunk and captures the final result.
module dot_product_feeder #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              total,
    dot_product_feeder_if.master     bus,
    output logic [element_width-1:0] result,
    output logic                     result_valid,
    output logic                     busy,
    output logic [2:0]               state_dbg
);
    localparam int          CW    = element_width * no_of_units;
    localparam logic [31:0] UNITS = 32'(no_of_units);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        PRESENT   = 3'd3,
        WAIT_FIN  = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0]              chunk_cnt_q, chunk_cnt_d;
    logic [31:0]              n_chunks_q, n_chunks_d;
    logic [31:0]              rem_q, rem_d;
    logic                     mem_rd_en_q, mem_rd_en_d;
    logic [addr_width-1:0]    mem_addr_q, mem_addr_d;
    logic [CW-1:0]            a_q, a_d;
    logic [CW-1:0]            b_q, b_d;
    logic                     present_q, present_d;
    logic [element_width-1:0] result_q, result_d;
    logic                     result_valid_q, result_valid_d;
    logic                     accept;
    logic                     xfer;
    logic                     last_chunk;

    assign accept     = (state_q == IDLE) && start;
    assign xfer       = (state_q == PRESENT) && bus.I_am_ready;
    assign last_chunk = (chunk_cnt_q + 32'd1 == n_chunks_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = (total == 32'd0) ? DONE : FETCH;
            FETCH:     state_d = WAIT_DATA;
            WAIT_DATA: state_d = PRESENT;
            PRESENT:   if (bus.I_am_ready) state_d = last_chunk ? WAIT_FIN : FETCH;
            WAIT_FIN:  if (bus.finish) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        chunk_cnt_d = chunk_cnt_q;
        n_chunks_d  = n_chunks_q;
        rem_d       = rem_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;

        if (accept) begin
            chunk_cnt_d = 32'd0;
            // Split form of ceil() so totals near 2^32 cannot overflow.
            n_chunks_d  = total / UNITS + (((total % UNITS) != 32'd0) ? 32'd1 : 32'd0);
            rem_d       = total % UNITS;
            if (total == 32'd0) result_d = '0;
        end

        if (state_q == WAIT_DATA) begin
            a_d = bus.mem_a_data;
            b_d = bus.mem_b_data;
            if (last_chunk && rem_q != 32'd0) begin
                for (int i = 0; i < no_of_units; i++) begin
                    if (32'(i) >= rem_q) begin
                        a_d[i*element_width +: element_width] = '0;
                        b_d[i*element_width +: element_width] = '0;
                    end
                end
            end
        end

        if (xfer) chunk_cnt_d = chunk_cnt_q + 32'd1;
        if (state_q == WAIT_FIN && bus.finish) result_d = bus.dot_product_output;

        // Registered strobes follow the state being entered so they line up with it.
        mem_rd_en_d    = (state_d == FETCH);
        mem_addr_d     = (state_d == FETCH) ? chunk_cnt_d[addr_width-1:0] : mem_addr_q;
        present_d      = (state_d == PRESENT);
        result_valid_d = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_cnt_q    <= '0;
            n_chunks_q     <= '0;
            rem_q          <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            a_q            <= '0;
            b_q            <= '0;
            present_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            chunk_cnt_q    <= chunk_cnt_d;
            n_chunks_q     <= n_chunks_d;
            rem_q          <= rem_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_addr_q     <= mem_addr_d;
            a_q            <= a_d;
            b_q            <= b_d;
            present_q      <= present_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.mem_rd_en                 = mem_rd_en_q;
    assign bus.mem_addr                  = mem_addr_q;
    assign bus.first_row_plus_additional = a_q;
    assign bus.vector2                   = b_q;
    assign bus.outsider_read_now         = present_q;
    assign result                        = result_q;
    assign result_valid                  = result_valid_q;
    assign busy                          = (state_q != IDLE);
    assign state_dbg                     = state_q;
endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: random vectors in a modelled memory, a scoreboard
// of expected chunk pairs / addresses / results, and a monitor that checks them.
module tb_dot_product_feeder;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int AW = 16;
    localparam int CH = W * N;
    localparam int CW = 2 * CH;
    localparam int MEM_DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   total;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          busy;
    logic [2:0]    state_dbg;

    dot_product_feeder_if #(.element_width(W), .no_of_units(N), .addr_width(AW)) bus ();

    dot_product_feeder #(.element_width(W), .no_of_units(N), .addr_width(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .total        (total),
        .bus          (bus),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ---------------- scoreboard state ----------------
    logic [CW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [W-1:0]  res_q[$];
    logic [CH-1:0] mem_a [MEM_DEPTH];
    logic [CH-1:0] mem_b [MEM_DEPTH];

    int n_vec = 0;
    int n_err = 0;
    int xfer_cnt = 0;
    int rv_cnt = 0;
    int rv_cyc = 0;
    int start_cyc = 0;
    int base_xfer = 0;
    int job_chunks = 0;
    logic [W-1:0] job_res = '0;
    logic [W-1:0] last_res = '0;
    int unsigned ready_pct = 100;
    bit hold_req = 1'b0;
    int rdy_held = 0;
    bit rsp_pending = 1'b0;
    int rsp_addr = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not allowed here", name);
    endtask

    function automatic logic [CH-1:0] rand_chunk();
        logic [CH-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    // ---------------- memory model: data valid only the cycle after mem_rd_en ----------------
    initial begin
        bus.mem_a_data = '0;
        bus.mem_b_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_pending && rsp_addr < MEM_DEPTH) begin
                bus.mem_a_data = mem_a[rsp_addr];
                bus.mem_b_data = mem_b[rsp_addr];
            end else begin
                bus.mem_a_data = rand_chunk();
                bus.mem_b_data = rand_chunk();
            end
            rsp_pending = bus.mem_rd_en;
            rsp_addr    = int'(bus.mem_addr);
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        bus.I_am_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!hold_req) rdy_held = 0;
            if (hold_req && rdy_held < 5) begin
                bus.I_am_ready = 1'b0;
                if (bus.outsider_read_now) rdy_held++;
            end else begin
                bus.I_am_ready = ($urandom_range(1, 100) <= ready_pct);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic          prev_hold;
        logic          prev_rd;
        logic          prev_rv;
        logic [CW-1:0] prev_data;
        logic [CW-1:0] cur;
        prev_hold = 1'b0;
        prev_rd   = 1'b0;
        prev_rv   = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
                prev_rd   = 1'b0;
                prev_rv   = 1'b0;
            end else begin
                cur = {bus.first_row_plus_additional, bus.vector2};
                if (prev_hold) begin
                    check("hold_valid", CW'(bus.outsider_read_now), CW'(1));
                    check("hold_data", cur, prev_data);
                end
                if (bus.outsider_read_now && bus.I_am_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) fail_now("extra_transfer");
                    else check("chunk", cur, exp_q.pop_front());
                end
                prev_hold = bus.outsider_read_now && !bus.I_am_ready;
                prev_data = cur;

                if (bus.mem_rd_en) begin
                    if (prev_rd) fail_now("rd_en_two_cycles");
                    if (addr_q.size() == 0) fail_now("extra_mem_read");
                    else check("mem_addr", CW'(bus.mem_addr), CW'(addr_q.pop_front()));
                end
                prev_rd = bus.mem_rd_en;

                if (result_valid) begin
                    rv_cnt++;
                    rv_cyc = cyc;
                    if (prev_rv) fail_now("result_valid_two_cycles");
                    if (res_q.size() == 0) fail_now("extra_result_valid");
                    else check("result", CW'(result), CW'(res_q.pop_front()));
                end
                prev_rv = result_valid;
            end
        end
    end

    // ---------------- reference model and drivers ----------------
    task automatic fill_random();
        for (int k = 0; k < MEM_DEPTH; k++) begin
            mem_a[k] = rand_chunk();
            mem_b[k] = rand_chunk();
        end
    endtask

    task automatic fill_const(input logic [W-1:0] va, input logic [W-1:0] vb);
        for (int k = 0; k < MEM_DEPTH; k++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[k][i*W +: W] = va;
                mem_b[k][i*W +: W] = vb;
            end
        end
    endtask

    // Vector element e lives at chunk e/N, lane e%N; anything at or past t is padding.
    task automatic prep_job(input int t);
        int n;
        logic [CH-1:0] ea;
        logic [CH-1:0] eb;
        logic [W-1:0]  sum;
        n   = (t + N - 1) / N;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            ea = mem_a[k];
            eb = mem_b[k];
            for (int i = 0; i < N; i++) begin
                if (k * N + i >= t) begin
                    ea[i*W +: W] = '0;
                    eb[i*W +: W] = '0;
                end else begin
                    sum = sum + ea[i*W +: W] * eb[i*W +: W];
                end
            end
            exp_q.push_back({ea, eb});
            addr_q.push_back(AW'(k));
        end
        res_q.push_back(sum);
        job_res    = sum;
        job_chunks = n;
    endtask

    task automatic kick(input int t);
        @(posedge clk);
        #1;
        start     = 1'b1;
        total     = 32'(t);
        start_cyc = cyc;
        base_xfer = xfer_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        total = $urandom;
    endtask

    task automatic finish_job(input bit glitch);
        int k;
        int delay;
        int base_rv;
        bit fin_done;
        k        = 0;
        delay    = $urandom_range(0, 3);
        base_rv  = rv_cnt;
        fin_done = 1'b0;
        while (rv_cnt == base_rv && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
            start  = 1'b0;
            bus.finish = 1'b0;
            bus.dot_product_output = $urandom;
            if (!fin_done && job_chunks > 0 && (xfer_cnt - base_xfer) >= job_chunks) begin
                if (delay == 0) begin
                    bus.finish = 1'b1;
                    bus.dot_product_output = job_res;
                    fin_done = 1'b1;
                end else begin
                    delay--;
                end
            end else if (glitch && bus.outsider_read_now && $urandom_range(0, 2) == 0) begin
                bus.finish = 1'b1;
                bus.dot_product_output = ~job_res;
            end
            if (glitch && busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                total = 32'($urandom_range(1, 120));
            end
        end
        start = 1'b0;
        bus.finish = 1'b0;
        if (rv_cnt == base_rv) fail_now("job_timeout");
        last_res = job_res;
    endtask

    // Stray finish pulses while idle must not disturb the held result.
    task automatic idle_check(input string name);
        int base_rv;
        base_rv = rv_cnt;
        repeat (4) begin
            @(posedge clk);
            #1;
            bus.finish = 1'b1;
            bus.dot_product_output = $urandom;
        end
        bus.finish = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_busy"}, CW'(busy), CW'(0));
        check({name, "_result_held"}, CW'(result), CW'(last_res));
        check({name, "_no_extra_rv"}, CW'(rv_cnt - base_rv), CW'(0));
        check({name, "_chunks_left"}, CW'(exp_q.size()), CW'(0));
        check({name, "_reads_left"}, CW'(addr_q.size()), CW'(0));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_rd_en"}, CW'(bus.mem_rd_en), CW'(0));
        check({name, "_addr"}, CW'(bus.mem_addr), CW'(0));
        check({name, "_valid"}, CW'(bus.outsider_read_now), CW'(0));
        check({name, "_data"}, {bus.first_row_plus_additional, bus.vector2}, CW'(0));
        check({name, "_result"}, CW'(result), CW'(0));
        check({name, "_result_valid"}, CW'(result_valid), CW'(0));
        check({name, "_busy"}, CW'(busy), CW'(0));
        check({name, "_state"}, CW'(state_dbg), CW'(0));
    endtask

    initial begin
        int k;
        int base_rv;
        int t;
        reset = 1'b1;
        start = 1'b0;
        total = '0;
        bus.finish = 1'b0;
        bus.dot_product_output = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        // Test 1: all-ones times all-twos, 16 elements
        fill_const(32'd1, 32'd2);
        ready_pct = 100;
        prep_job(16);
        kick(16);
        finish_job(1'b0);
        check("t1_transfers", CW'(xfer_cnt - base_xfer), CW'(2));
        check("t1_result", CW'(result), CW'(32));
        idle_check("t1");

        // Test 2: 13 elements, tail lanes 5..7 padded
        fill_random();
        prep_job(13);
        kick(13);
        finish_job(1'b0);
        check("t2_transfers", CW'(xfer_cnt - base_xfer), CW'(2));
        idle_check("t2");

        // Test 3: consumer stalls 5 cycles on the first presented chunk
        fill_random();
        hold_req = 1'b1;
        prep_job(16);
        kick(16);
        finish_job(1'b0);
        hold_req = 1'b0;
        check("t3_stall_seen", CW'(rdy_held), CW'(5));
        check("t3_transfers", CW'(xfer_cnt - base_xfer), CW'(2));
        idle_check("t3");

        // Test 5: reset during chunk 1 of a 4-chunk job, with start/finish also high
        fill_random();
        prep_job(32);
        kick(32);
        k = 0;
        while (!(bus.mem_rd_en && bus.mem_addr == AW'(1)) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) fail_now("t5_chunk1_timeout");
        reset      = 1'b1;
        start      = 1'b1;
        total      = 32'd77;
        bus.finish = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        start      = 1'b0;
        bus.finish = 1'b0;
        exp_q.delete();
        addr_q.delete();
        res_q.delete();
        last_res = '0;
        check_reset_state("t5_reset");
        base_rv = rv_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_rv_after_abort", CW'(rv_cnt - base_rv), CW'(0));
        fill_random();
        prep_job(8);
        kick(8);
        finish_job(1'b0);
        check("t5_transfers", CW'(xfer_cnt - base_xfer), CW'(1));
        idle_check("t5");

        // Test 4: empty job, plus a start landing in the DONE cycle
        prep_job(0);
        kick(0);
        start = 1'b1;
        total = 32'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_job(1'b0);
        check("t4_latency", CW'(rv_cyc - start_cyc), CW'(2));
        check("t4_result", CW'(result), CW'(0));
        idle_check("t4");

        // Test 6 and random jobs: stray start/finish while busy, random backpressure
        for (int j = 0; j < 8; j++) begin
            t = (j == 0) ? 64 : int'($urandom_range(1, N * MEM_DEPTH));
            ready_pct = $urandom_range(30, 100);
            fill_random();
            prep_job(t);
            kick(t);
            finish_job(1'b1);
            check("rnd_transfers", CW'(xfer_cnt - base_xfer), CW'((t + N - 1) / N));
            idle_check("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
